clock_ctrl: RTL
===============

Name: clock_ctrl

Overview:
Timekeeping controller that sequences the chained seconds/minutes/hours counters of the digital clock.
- Divides clk down to a 1 Hz advance tick.
- Runs a user set-mode state machine driven by two pre-debounced button pulses.
- Produces the registered time fields consumed by the display/7-segment path.

Parameters:
TICK_DIV, 50000000, clk cycles per time-advance tick (benches override to a small value, e.g. 4)
HOUR_MAX, 23, last hour value before wrap to 0 (24-hour format)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
i_mode  input  1  one-cycle pulse, advance set-mode state
i_inc  input  1  one-cycle pulse, increment currently selected field
o_sec  output  6  seconds, 0..59
o_min  output  6  minutes, 0..59
o_hour  output  5  hours, 0..HOUR_MAX
o_mode  output  2  current state encoding (for display blink/field highlight)
o_tick  output  1  one-cycle pulse each time the divider expires in NORMAL

Behaviour:
- Reset (async assert, sync release to clk): o_sec=o_min=o_hour=0, o_mode=NORMAL, divider=0, o_tick=0.
- All outputs are registered. An update from an input pulse or tick is visible the cycle after it.
- Divider:
  - Counts 0..TICK_DIV-1 only in NORMAL.
  - At TICK_DIV-1 it wraps to 0, and o_tick=1 for exactly that one cycle.
  - In any SET state the divider is held at 0 and o_tick=0.
- FSM states: NORMAL=0, SET_HOUR=1, SET_MIN=2, SET_SEC=3.
  - i_mode advances NORMAL->SET_HOUR->SET_MIN->SET_SEC->NORMAL.
  - On returning to NORMAL the divider starts from 0, so the first second is a full TICK_DIV cycles.
- NORMAL, on tick:
  - sec+1.
  - sec>=59 -> sec=0 and carry to min.
  - min>=59 with carry -> min=0 and carry to hour.
  - hour>=HOUR_MAX with carry -> hour=0.
  - The ">=" compares also force any out-of-range value back to 0.
  - i_inc is ignored in NORMAL.
- SET_x, on i_inc:
  - The selected field increments modulo its range (59->0, HOUR_MAX->0).
  - No carry into any other field. The other fields are frozen.
- Simultaneous i_mode and i_inc: the mode change wins and i_inc is dropped that cycle.
- Simultaneous tick and i_mode in NORMAL: the tick's time advance is applied and the state moves to SET_HOUR in the same cycle.
- Held/multi-cycle i_inc: increments once per cycle asserted. Edge detection is the debouncer's job, not this block's.
- Reset mid-operation: immediate return to reset values. No partial update survives.

Decomposition:
- Shared package clock_pkg holds:
  - state encodings (NORMAL, SET_HOUR, SET_MIN, SET_SEC, 2-bit type)
  - SEC_MAX=59, MIN_MAX=59, field widths (6, 6, 5)
- One natural sub-module, clock_tick_div: the parameterised divider.
  - Inputs: clk, rst_n, en, clr.
  - Output: tick.
  - Instantiated once.
- The field counters and FSM stay in clock_ctrl.

Test Plan:
- Reset release, TICK_DIV=4, no buttons -> o_tick pulses every 4 cycles; o_sec = 1, 2, 3 after ticks 1-3; o_min=o_hour=0.
- Preload 23:59:58 via set mode, return to NORMAL -> next tick gives 23:59:59, following tick gives 00:00:00; exactly one o_tick per step.
- i_mode x1 then i_inc x25 -> o_mode=1, o_hour sequence ends 0 (24 increments wrap 23->0) then 1; o_min/o_sec unchanged; o_tick stays 0.
- In SET_MIN with min=59, one i_inc -> min=0, hour unchanged (no carry); four i_mode pulses from NORMAL -> o_mode back to 0, then first tick exactly 4 cycles later.
- i_mode and i_inc asserted same cycle in NORMAL -> o_mode=1, o_hour unchanged; same cycle as a tick -> o_sec advances and o_mode=1.
- rst_n pulled low mid-count at 12:34:56 in SET_MIN -> all outputs 0 and o_mode=0 immediately (asynchronous), counting resumes from 00:00:00.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared state encodings and time-field limits for the digital clock
package clock_pkg;
    typedef logic [1:0] mode_t;
    localparam mode_t NORMAL   = 2'd0;
    localparam mode_t SET_HOUR = 2'd1;
    localparam mode_t SET_MIN  = 2'd2;
    localparam mode_t SET_SEC  = 2'd3;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HOUR_W  = 5;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
endpackage

// File: rtl/clock_tick_div.sv
// clock_tick_div: divides clk to a one-cycle registered tick every TICK_DIV enabled cycles
module clock_tick_div #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;
    logic         wrap;
    always_comb begin
        wrap   = cnt_q == W'(TICK_DIV - 1);
        tick_d = en && !clr && wrap;
        cnt_d  = clr ? '0 : !en ? cnt_q : wrap ? '0 : cnt_q + W'(1);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end
    assign tick = tick_q;
endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: time-of-day counters with a button-driven set mode
// and a divided advance tick; all outputs registered.
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int HOUR_MAX = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_mode,
    input  logic       i_inc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [1:0] o_mode,
    output logic       o_tick
);
    mode_t             state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;
    logic tick, div_en, adv, inc, sec_wrap, min_wrap, hour_wrap;
    // A mode press stops the divider in the same cycle so a SET state never sees a tick
    assign div_en = state_q == NORMAL && !i_mode;
    clock_tick_div #(.TICK_DIV(TICK_DIV)) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (div_en),
        .clr  (!div_en),
        .tick (tick)
    );
    always_comb begin
        state_d   = i_mode ? state_q + 2'd1 : state_q;
        adv       = tick && state_q == NORMAL;
        inc       = i_inc && !i_mode;
        sec_wrap  = sec_q >= SEC_W'(SEC_MAX);
        min_wrap  = min_q >= MIN_W'(MIN_MAX);
        hour_wrap = hour_q >= HOUR_W'(HOUR_MAX);
        sec_d  = (adv || (inc && state_q == SET_SEC))
               ? (sec_wrap ? '0 : sec_q + SEC_W'(1)) : sec_q;
        min_d  = ((adv && sec_wrap) || (inc && state_q == SET_MIN))
               ? (min_wrap ? '0 : min_q + MIN_W'(1)) : min_q;
        hour_d = ((adv && sec_wrap && min_wrap) || (inc && state_q == SET_HOUR))
               ? (hour_wrap ? '0 : hour_q + HOUR_W'(1)) : hour_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
        end
    end
    assign o_sec  = sec_q;
    assign o_min  = min_q;
    assign o_hour = hour_q;
    assign o_mode = state_q;
    assign o_tick = tick;
endmodule
